// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, redirect/squash handling, sticky misaligned fault.
// Optional opcode legality flag on out_illegal when FETCH_OPCODE_CHECK_EN is defined (tied to 0 otherwise).
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_pc,
  output logic        out_illegal,
  output logic        fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        squash;
  logic        bad_target;

  assign imem_req_addr = pc;
  assign bad_target    = redirect_valid && (redirect_target[1:0] != 2'b00);

`ifdef FETCH_OPCODE_CHECK_EN
  logic illegal_q;
  assign out_illegal = illegal_q;

  function automatic logic opcode_illegal(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
      7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011: opcode_illegal = 1'b0;
      default:                                        opcode_illegal = 1'b1;
    endcase
  endfunction
`else
  assign out_illegal = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      squash         <= 1'b0;
      imem_req_valid <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= 32'h0;
      out_pc         <= 32'h0;
      fault          <= 1'b0;
`ifdef FETCH_OPCODE_CHECK_EN
      illegal_q      <= 1'b0;
`endif
    end else if (state != FAULT && bad_target) begin
      state          <= FAULT;
      fault          <= 1'b1;
      squash         <= 1'b0;
      imem_req_valid <= 1'b0;
      out_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc <= redirect_target;
          state          <= REQ;
          imem_req_valid <= 1'b1;
        end
        REQ: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            // Handshake already happened at the old pc: its response must be dropped.
            if (imem_req_ready) begin
              squash         <= 1'b1;
              state          <= WAIT;
              imem_req_valid <= 1'b0;
            end
          end else if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            squash <= 1'b0;
            if (redirect_valid || squash) begin
              if (redirect_valid) pc <= redirect_target;
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end else begin
              out_data  <= imem_rsp_data;
              out_pc    <= pc;
              out_valid <= 1'b1;
              state     <= HOLD;
`ifdef FETCH_OPCODE_CHECK_EN
              illegal_q <= opcode_illegal(imem_rsp_data[6:0]);
`endif
            end
          end else if (redirect_valid) begin
            pc     <= redirect_target;
            squash <= 1'b1;
          end
        end
        HOLD: begin
          // A redirect wins over the sequential pc+4 even when the decoder consumes this cycle.
          if (redirect_valid || out_ready) begin
            pc             <= redirect_valid ? redirect_target : pc + 32'd4;
            out_valid      <= 1'b0;
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end
        end
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, stall, redirect/squash cases, wrap, fault and reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_pc(out_pc),
    .out_illegal(out_illegal),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full request/response/consume transaction starting from a REQ cycle.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word,
                           input logic exp_ill, input int hold_cycles);
    logic exp_i;
`ifdef FETCH_OPCODE_CHECK_EN
    exp_i = exp_ill;
`else
    exp_i = 1'b0;
`endif
    check_eq("req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check_eq("wait_req_valid", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = word;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    for (int i = 0; i <= hold_cycles; i++) begin
      check_eq("out_valid", 32'(out_valid), 32'd1);
      check_eq("out_data", out_data, word);
      check_eq("out_pc", out_pc, addr);
      check_eq("out_illegal", 32'(out_illegal), 32'(exp_i));
      check_eq("hold_no_req", 32'(imem_req_valid), 32'd0);
      if (i < hold_cycles) tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("consumed_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    out_ready       = 1'b0;
    tick();
    tick();
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", out_data, 32'h0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_illegal", 32'(out_illegal), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);

    rst = 1'b0;
    check_eq("first_cycle_no_req", 32'(imem_req_valid), 32'd0);
    tick();

    // Sequential fetches, then a 5-cycle decoder stall
    fetch_one(32'h0000_0000, 32'h0000_0013, 1'b0, 0);
    fetch_one(32'h0000_0004, 32'h00A0_0093, 1'b0, 0);
    fetch_one(32'h0000_0008, 32'h0010_8113, 1'b0, 0);
    fetch_one(32'h0000_000C, 32'h0020_01B7, 1'b0, 5);

    // Redirect while WAIT; stale response three cycles later
    check_eq("pre_squash_addr", imem_req_addr, 32'h0000_0010);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check_eq("squash_one_outstanding", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0013;
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("squash_drop_out_valid", 32'(out_valid), 32'd0);
    fetch_one(32'h0000_0100, 32'h0000_0033, 1'b0, 0);

    // Redirect coinciding with the response
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    imem_rsp_valid  = 1'b1;
    imem_rsp_data   = 32'hBAD1_0013;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    check_eq("coincide_out_valid", 32'(out_valid), 32'd0);
    fetch_one(32'h0000_0200, 32'h0000_0063, 1'b0, 0);

    // Redirect in HOLD together with out_ready
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_006F;
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("hold_pc", out_pc, 32'h0000_0204);
    out_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0300;
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    check_eq("hold_redir_out_valid", 32'(out_valid), 32'd0);
    check_eq("hold_redir_addr", imem_req_addr, 32'h0000_0300);

    // Redirect in REQ without ready: withdraw, request target next cycle
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0400;
    tick();
    redirect_valid = 1'b0;
    check_eq("withdraw_valid", 32'(imem_req_valid), 32'd1);
    check_eq("withdraw_addr", imem_req_addr, 32'h0000_0400);

    // Redirect in REQ with ready: counts as issued, response squashed
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0500;
    imem_req_ready  = 1'b1;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    check_eq("req_squash_no_req", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD2_0013;
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("req_squash_out_valid", 32'(out_valid), 32'd0);
    check_eq("req_squash_addr", imem_req_addr, 32'h0000_0500);

    // PC wrap and opcode check
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    fetch_one(32'hFFFF_FFFC, 32'h0000_0073, 1'b1, 0);
    check_eq("wrap_fault", 32'(fault), 32'd0);
    fetch_one(32'h0000_0000, 32'h0000_0033, 1'b0, 0);

    // Misaligned redirect: sticky fault until reset
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("fault_set", 32'(fault), 32'd1);
      check_eq("fault_no_req", 32'(imem_req_valid), 32'd0);
      check_eq("fault_no_out", 32'(out_valid), 32'd0);
      imem_req_ready  = 1'b1;
      imem_rsp_valid  = 1'b1;
      redirect_valid  = (i == 1);
      redirect_target = 32'h0000_0040;
      tick();
    end
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;

    // Reset with a response still arriving afterwards
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rerst_fault", 32'(fault), 32'd0);
    check_eq("rerst_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    check_eq("rerst_out_valid", 32'(out_valid), 32'd0);
    fetch_one(32'h0000_0000, 32'h0000_0017, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
- REQ-001: Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
- REQ-002: clk  input  1  is the single clock; all state updates on its rising edge.
- REQ-003: rst  input  1  is the reset: synchronous, active-high.
- REQ-004: imem_req_valid  output  1  requests the instruction word at imem_req_addr.
- REQ-005: imem_req_addr  output  32  is the word address (current PC).
- REQ-006: imem_req_ready  input  1  means the memory accepts the request this cycle.
- REQ-007: imem_rsp_valid  input  1  means imem_rsp_data holds the response to the oldest accepted request.
- REQ-008: imem_rsp_data  input  32  is the instruction word.
- REQ-009: redirect_valid  input  1  means a branch/jump redirect is requested this cycle.
- REQ-010: redirect_target  input  32  is the new PC.
- REQ-011: out_valid  output  1  means out_data/out_pc hold an instruction for the decoder.
- REQ-012: out_ready  input  1  means the decoder consumes the instruction this cycle.
- REQ-013: out_data  output  32  is the instruction word.
- REQ-014: out_pc  output  32  is the PC of out_data.
- REQ-015: out_illegal  output  1  is the opcode-check flag (see Configuration).
- REQ-016: fault  output  1  is a sticky misaligned-redirect fault.

Function
- REQ-017: The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and FAULT.
- REQ-018: IDLE SHALL go to REQ unconditionally.
- REQ-019: In REQ, imem_req_valid=1 and imem_req_addr=pc; imem_req_ready=1 SHALL go to WAIT.
- REQ-020: In WAIT, an imem_rsp_valid=1 (not squashed) SHALL register data/pc into out_data/out_pc and go to HOLD; out_valid rises in the next cycle (1-cycle latency from the response).
- REQ-021: In HOLD, out_valid=1 and the outputs SHALL stay stable until out_ready=1; then pc<=pc+4 and the FSM goes to REQ.
- REQ-022: pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no fault.
- REQ-023: At most one request SHALL be outstanding at any time.
- REQ-024: redirect_valid=1 in REQ/HOLD/IDLE SHALL load pc<=redirect_target and go to REQ; any held instruction SHALL be dropped, with out_valid=0 in the next cycle.
- REQ-025: redirect in REQ with imem_req_ready=1 in the same cycle SHALL count as an issued request: set squash, go to WAIT.
- REQ-026: redirect in WAIT without imem_rsp_valid SHALL set squash and stay in WAIT; the next response SHALL be discarded, squash cleared, and the FSM goes to REQ.
- REQ-027: redirect in WAIT coinciding with imem_rsp_valid SHALL discard that response and go to REQ without setting squash.
- REQ-028: redirect in HOLD coinciding with out_ready=1 SHALL complete the handshake, then apply the redirect (pc=target, not pc+4).
- REQ-029: redirect in REQ with imem_req_ready=0 SHALL withdraw the request; the target is requested in the next cycle.
- REQ-030: A redirect_target with bits [1:0]!=0 SHALL set fault=1, go to FAULT and keep all valids at 0; FAULT SHALL be left only by rst.

Reset
- REQ-031: rst=1 at a clock edge SHALL force IDLE, pc=RESET_PC, squash=0 and these outputs: imem_req_valid=0, out_valid=0, out_data=0, out_pc=0, out_illegal=0, fault=0.
- REQ-032: Reset SHALL override everything, including mid-request; a response arriving after reset with no new request issued SHALL be ignored.
- REQ-033: The first imem_req_valid SHALL occur in the second cycle after rst deasserts.

Configuration
- REQ-034: With FETCH_OPCODE_CHECK_EN defined, out_illegal SHALL be registered with out_data and equal 1 when the opcode is not one of LUI, AUIPC, JAL, JALR, LOAD, STORE, OP_IMM, OP or BRANCH.
- REQ-035: Without FETCH_OPCODE_CHECK_EN, the out_illegal port SHALL remain and be tied to 0.

Verification
- REQ-036: Reset release, memory always ready with 1-cycle response -> requests at 0x0,0x4,0x8; out_pc follows in order; out_data matches memory.
- REQ-037: out_ready held 0 for 5 cycles in HOLD -> out_data/out_pc stable, no new imem request; release -> next request at pc+4.
- REQ-038: Redirect to 0x100 while WAIT, response arrives 3 cycles later -> stale word discarded, next request at 0x100, out_pc=0x100.
- REQ-039: Redirect to 0x102 -> fault=1, no further requests until rst; rst -> fetch restarts at RESET_PC.
- REQ-040: PC at 0xFFFF_FFFC consumed -> next request at 0x0; with FETCH_OPCODE_CHECK_EN, word 0x0000_0073 -> out_illegal=1 and 0x0000_0033 -> out_illegal=0.
